// File: rtl/imem_loader_if.sv
// Byte-stream link into the imem loader: valid/ready handshake carrying one byte per transfer.
// The host drives through the master modport; the loader consumes through the slave modport.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: unpacks a framed byte stream (16-bit word count, then data) into N-bit imem writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before DONE.
module imem_loader #(
    parameter int N         = 32,
    parameter int ADDR_W    = 7,
    parameter int DEPTH     = 128,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.slave      byte_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int          BPW    = N / 8;
    localparam int          BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned LIMIT  = DEPTH - BASE_ADDR;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, CHK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, DONE, ERR} state_t;
`endif

    state_t              state, state_nxt;
    logic                ready;
    logic                accept;
    logic [7:0]          cnt_lo;
    logic [15:0]         words_left;
    logic [ADDR_W-1:0]   word_addr;
    logic [BIDX_W-1:0]   byte_idx;
    logic [N-1:0]        word_sh;
    logic [N-1:0]        word_next;
    logic                last_byte;
    logic                last_word;
    logic [31:0]         hdr_count;
    logic                hdr_bad;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          chk_acc;
`endif

    assign byte_in.in_ready = ready;
    assign accept    = byte_in.in_valid & ready;
    assign last_byte = (byte_idx == BIDX_W'(BPW - 1));
    assign last_word = last_byte && (words_left == 16'd1);
    assign hdr_count = {16'd0, byte_in.in_data, cnt_lo};
    assign hdr_bad   = (hdr_count == 32'd0) || (hdr_count > LIMIT);
    // Little-endian packing: bytes enter at the top and shift down, so the first lands in [7:0].
    assign word_next = (word_sh >> 8) | (N'(byte_in.in_data) << (N - 8));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        cpu_hold  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = HDR_LO;
            end
            HDR_LO: begin
                ready    = 1'b1;
                cpu_hold = 1'b1;
                if (accept) state_nxt = HDR_HI;
            end
            HDR_HI: begin
                ready    = 1'b1;
                cpu_hold = 1'b1;
                if (accept) state_nxt = hdr_bad ? ERR : DATA;
            end
            DATA: begin
                ready    = 1'b1;
                cpu_hold = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept && last_word) state_nxt = CHK;
`else
                if (accept && last_word) state_nxt = DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                ready    = 1'b1;
                cpu_hold = 1'b1;
                if (accept) state_nxt = (byte_in.in_data == chk_acc) ? DONE : ERR;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = HDR_LO;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_nxt = HDR_LO;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cnt_lo     <= '0;
            words_left <= '0;
            word_addr  <= '0;
            byte_idx   <= '0;
            word_sh    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc    <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    HDR_LO: begin
                        cnt_lo <= byte_in.in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_acc <= byte_in.in_data;
`endif
                    end
                    HDR_HI: begin
                        words_left <= {byte_in.in_data, cnt_lo};
                        word_addr  <= ADDR_W'(BASE_ADDR);
                        byte_idx   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_acc <= chk_acc ^ byte_in.in_data;
`endif
                    end
                    DATA: begin
                        word_sh <= word_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_acc <= chk_acc ^ byte_in.in_data;
`endif
                        if (last_byte) begin
                            mem_we     <= 1'b1;
                            mem_addr   <= word_addr;
                            mem_wdata  <= word_next;
                            word_addr  <= word_addr + ADDR_W'(1);
                            words_left <= words_left - 16'd1;
                            byte_idx   <= '0;
                        end else begin
                            byte_idx <= byte_idx + BIDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (BASE_ADDR 0 and 53) fed framed byte streams.
module tb_imem_loader;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic we0, we1, hold0, hold1, done0, done1, err0, err1;
    logic [6:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;

    int n_checks = 0;
    int n_fail   = 0;
    int dup_we   = 0;
    logic       prev_we0 = 1'b0;
    logic [6:0] prev_addr0 = '0;
    logic snap_err, snap_done, snap_hold;

    wr_t        wq0[$], wq1[$], exp_wr[$];
    logic [7:0] frame[$];

    always #5 clk = ~clk;

    imem_loader_if if0();
    imem_loader_if if1();

    imem_loader #(.N(32), .ADDR_W(7), .DEPTH(128), .BASE_ADDR(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .byte_in(if0.slave),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .cpu_hold(hold0), .done(done0), .error(err0)
    );

    imem_loader #(.N(32), .ADDR_W(7), .DEPTH(128), .BASE_ADDR(53)) u_dut53 (
        .clk(clk), .reset(reset), .start(start1), .byte_in(if1.slave),
        .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .cpu_hold(hold1), .done(done1), .error(err1)
    );

    // Write monitor: records each imem write and flags a strobe repeated on the same address.
    always @(negedge clk) begin
        if (we0) begin
            if (prev_we0 && prev_addr0 == addr0) dup_we++;
            wq0.push_back({addr0, wdata0});
        end
        prev_we0   = we0;
        prev_addr0 = addr0;
        if (we1) wq1.push_back({addr1, wdata1});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] b, input logic s);
        if (sel == 0) begin
            if0.in_valid = v; if0.in_data = b; start0 = s;
        end else begin
            if1.in_valid = v; if1.in_data = b; start1 = s;
        end
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input logic with_start);
        int n = 0;
        @(negedge clk);
        drive(sel, 1'b1, b, with_start);
        while (!((sel == 0) ? if0.in_ready : if1.in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk);
        drive(sel, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        drive(sel, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic run_frame(input int sel, input int max_gap, input int start_at);
        pulse_start(sel);
        foreach (frame[i]) begin
            send_byte(sel, frame[i], i == start_at);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
        end
        @(negedge clk);
        snap_err  = (sel == 0) ? err0  : err1;
        snap_done = (sel == 0) ? done0 : done1;
        snap_hold = (sel == 0) ? hold0 : hold1;
        @(negedge clk);
    endtask

    task automatic check_writes(input int sel, input string tag);
        wr_t q[$];
        if (sel == 0) q = wq0; else q = wq1;
        check($sformatf("%s_nwr", tag), q.size(), exp_wr.size());
        for (int i = 0; i < q.size() && i < exp_wr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(q[i].addr), 32'(exp_wr[i].addr));
            check($sformatf("%s_data%0d", tag, i), q[i].data, exp_wr[i].data);
        end
    endtask

    task automatic check_status(input string tag, input logic e_done, input logic e_err);
        check($sformatf("%s_done", tag), 32'(snap_done), 32'(e_done));
        check($sformatf("%s_error", tag), 32'(snap_err), 32'(e_err));
        check($sformatf("%s_hold", tag), 32'(snap_hold), 32'd0);
    endtask

    function automatic void add_chk(input logic [7:0] flip);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        foreach (frame[i]) x ^= frame[i];
        frame.push_back(x ^ flip);
`else
        if (flip != 8'h00) frame.push_back(flip);
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(if0.in_ready), 32'd0);
        check({tag, "_mem_we"},   32'(we0),   32'd0);
        check({tag, "_mem_addr"}, 32'(addr0), 32'd0);
        check({tag, "_mem_wdata"}, wdata0,    32'd0);
        check({tag, "_cpu_hold"}, 32'(hold0), 32'd0);
        check({tag, "_done"},     32'(done0), 32'd0);
        check({tag, "_error"},    32'(err0),  32'd0);
    endtask

    initial begin
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Basic two-word image
        wq0.delete();
        frame = '{8'h02, 8'h00, 8'h41, 8'h00, 8'h03, 8'h8b, 8'h00, 8'h02, 8'h1f, 8'hd6};
        add_chk(8'h00);
        exp_wr = '{{7'd0, 32'h8b030041}, {7'd1, 32'hd61f0200}};
        run_frame(0, 0, -1);
        check_writes(0, "basic");
        check_status("basic", 1'b1, 1'b0);

        // Header count 0 and 129 are rejected without writes
        wq0.delete();
        exp_wr.delete();
        frame = '{8'h00, 8'h00};
        run_frame(0, 0, -1);
        check_status("cnt0", 1'b0, 1'b1);
        check_writes(0, "cnt0");
        frame = '{8'h81, 8'h00};
        run_frame(0, 0, -1);
        check_status("cnt129", 1'b0, 1'b1);
        check_writes(0, "cnt129");

        // Non-zero base address, then one word too many for the space above it
        wq1.delete();
        frame = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                  8'h07, 8'h08, 8'h09, 8'h0a, 8'h0b, 8'h0c};
        add_chk(8'h00);
        exp_wr = '{{7'd53, 32'h04030201}, {7'd54, 32'h08070605}, {7'd55, 32'h0c0b0a09}};
        run_frame(1, 0, -1);
        check_writes(1, "base53");
        check_status("base53", 1'b1, 1'b0);
        wq1.delete();
        exp_wr.delete();
        frame = '{8'h4c, 8'h00};
        run_frame(1, 0, -1);
        check_status("base53_cnt76", 1'b0, 1'b1);
        check_writes(1, "base53_cnt76");

        // Four words back-to-back, then the same frame with random valid gaps
        frame = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                  8'h99, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff, 8'h00};
        add_chk(8'h00);
        exp_wr = '{{7'd0, 32'h44332211}, {7'd1, 32'h88776655},
                   {7'd2, 32'hccbbaa99}, {7'd3, 32'h00ffeedd}};
        wq0.delete();
        run_frame(0, 0, -1);
        check_writes(0, "b2b");
        check_status("b2b", 1'b1, 1'b0);
        wq0.delete();
        run_frame(0, 3, -1);
        check_writes(0, "gaps");
        check_status("gaps", 1'b1, 1'b0);
        check("dup_we", 32'(dup_we), 32'd0);

        // Reset mid-load: count 128 is accepted, then reset after six data bytes
        wq0.delete();
        pulse_start(0);
        send_byte(0, 8'h80, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        @(negedge clk);
        check("cnt128_error", 32'(err0), 32'd0);
        check("cnt128_hold", 32'(hold0), 32'd1);
        for (int i = 0; i < 6; i++) send_byte(0, 8'ha1 + 8'(i), 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        exp_wr = '{{7'd0, 32'ha4a3a2a1}};
        check_writes(0, "midrst");
        reset = 1'b0;

        // Reload after reset, with a start pulse during DATA that must be ignored
        wq0.delete();
        frame = '{8'h02, 8'h00, 8'h41, 8'h00, 8'h03, 8'h8b, 8'h00, 8'h02, 8'h1f, 8'hd6};
        add_chk(8'h00);
        exp_wr = '{{7'd0, 32'h8b030041}, {7'd1, 32'hd61f0200}};
        run_frame(0, 0, 6);
        check_writes(0, "reload");
        check_status("reload", 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Corrupted checksum: words stay written, load reports error
        wq0.delete();
        frame = '{8'h02, 8'h00, 8'h41, 8'h00, 8'h03, 8'h8b, 8'h00, 8'h02, 8'h1f, 8'hd6};
        add_chk(8'h5a);
        run_frame(0, 0, -1);
        check_writes(0, "badchk");
        check_status("badchk", 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
